// File: rtl/twofish_io_pkg.sv
// Shared sizes, state encoding and phase codes for the switch/LED Twofish front end.
package twofish_io_pkg;

  localparam int WORD_W  = 16;
  localparam int BLOCK_W = 128;
  localparam int WORDS   = BLOCK_W / WORD_W;
  localparam int IDX_W   = 3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_TEXT  = 3'd0,
    S_KEY   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] PH_TEXT = 2'b00;
  localparam logic [1:0] PH_KEY  = 2'b01;
  localparam logic [1:0] PH_RUN  = 2'b10;
  localparam logic [1:0] PH_DONE = 2'b11;

  // Phase code shown on the LEDs for a given FSM state.
  function automatic logic [1:0] phase_of(input state_e s);
    logic [1:0] ph;
    case (s)
      S_TEXT:  ph = PH_TEXT;
      S_KEY:   ph = PH_KEY;
      S_START: ph = PH_RUN;
      S_WAIT:  ph = PH_RUN;
      S_DONE:  ph = PH_DONE;
      default: ph = PH_TEXT;
    endcase
    return ph;
  endfunction

  // Replace word 'idx' (word 0 is the most significant) of a block with 'w'.
  function automatic logic [BLOCK_W-1:0] put_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [IDX_W-1:0]   idx,
                                                  input logic [WORD_W-1:0]  w);
    logic [BLOCK_W-1:0] r;
    r = blk;
    for (int i = 0; i < WORDS; i++) begin
      r[BLOCK_W-1-WORD_W*i -: WORD_W] = (idx == IDX_W'(i)) ? w : r[BLOCK_W-1-WORD_W*i -: WORD_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/switch_block_loader_if.sv
// Handshake and data bundle between the loader and the Twofish core.
interface switch_block_loader_if;

  logic [twofish_io_pkg::BLOCK_W-1:0] text_out;
  logic [twofish_io_pkg::BLOCK_W-1:0] key_out;
  logic                               mode_out;
  logic                               start;
  logic                               busy_in;
  logic                               done_in;

  modport master (
    output text_out, key_out, mode_out, start,
    input  busy_in, done_in
  );

  modport slave (
    input  text_out, key_out, mode_out, start,
    output busy_in, done_in
  );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a raw push-button.
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronise the button and remember the previous synchronised level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/switch_block_loader.sv
// Collects switch words into a text block and key, latches the mode and
// kicks the Twofish core with a one-cycle start pulse.
module switch_block_loader
  import twofish_io_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    bits,
  input  logic                 step_btn,
  input  logic                 mode_in,
  output logic                 mode_led,
  output logic [4:0]           state_led,
  switch_block_loader_if.master core
);

  logic               step_p;
  logic               mode_p;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [BLOCK_W-1:0] text_q,  text_d;
  logic [BLOCK_W-1:0] key_q,   key_d;
  logic               mode_q,  mode_d;
  logic               start_q, start_d;
  logic [4:0]         led_q,   led_d;

  btn_edge_sync u_step_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (step_btn),
    .pulse   (step_p)
  );

  btn_edge_sync u_mode_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (mode_in),
    .pulse   (mode_p)
  );

  // State, index, data and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_TEXT;
      idx_q   <= '0;
      text_q  <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      led_q   <= 5'b00000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      text_q  <= text_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      led_q   <= led_d;
    end
  end

  // Next state and word index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_TEXT, S_KEY: begin
        if (step_p) begin
          if (idx_q == IDX_LAST) begin
            state_d = (state_q == S_TEXT) ? S_KEY : S_START;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_START: begin
        if (!core.busy_in) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_START;
        end
        idx_d = '0;
      end
      S_WAIT: begin
        if (core.done_in) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
        idx_d = '0;
      end
      S_DONE: begin
        if (step_p) begin
          state_d = S_TEXT;
        end else begin
          state_d = S_DONE;
        end
        idx_d = '0;
      end
      default: begin
        state_d = S_TEXT;
        idx_d   = '0;
      end
    endcase
  end

  // Data capture, mode toggle, start pulse and LED value for the next cycle.
  always_comb begin
    text_d  = text_q;
    key_d   = key_q;
    mode_d  = mode_q;
    start_d = 1'b0;
    case (state_q)
      S_TEXT: begin
        if (step_p) begin
          text_d = put_word(text_q, idx_q, bits);
        end else begin
          text_d = text_q;
        end
        // Mode may only be changed before the first word is entered.
        if (mode_p && (idx_q == 3'd0)) begin
          mode_d = ~mode_q;
        end else begin
          mode_d = mode_q;
        end
      end
      S_KEY: begin
        if (step_p) begin
          key_d = put_word(key_q, idx_q, bits);
        end else begin
          key_d = key_q;
        end
      end
      S_START: begin
        start_d = ~core.busy_in;
      end
      S_WAIT: begin
        start_d = 1'b0;
      end
      S_DONE: begin
        if (step_p) begin
          text_d = '0;
          key_d  = '0;
        end else begin
          text_d = text_q;
          key_d  = key_q;
        end
      end
      default: begin
        text_d = '0;
        key_d  = '0;
        mode_d = 1'b0;
      end
    endcase

    if ((state_d == S_TEXT) || (state_d == S_KEY)) begin
      led_d = {phase_of(state_d), idx_d};
    end else begin
      led_d = {phase_of(state_d), 3'b000};
    end
  end

  assign core.text_out = text_q;
  assign core.key_out  = key_q;
  assign core.mode_out = mode_q;
  assign core.start    = start_q;
  assign mode_led      = mode_q;
  assign state_led     = led_q;

endmodule
